// File: rtl/io_port_ctrl_pkg.sv
// rtl/io_port_ctrl_pkg.sv - address map and segment encoding for the I/O port
// Purpose: shared constants for io_port_ctrl; no ports.
//   IO_BASE  - upper 12 address bits of the I/O window
//   IO_DISP  - display digit register (R/W)
//   IO_SW    - debounced switch levels (R)
//   IO_EDGE  - rising-edge event flags (R, clear-on-read)
//   hex_to_seg - hex digit to active-low {g,f,e,d,c,b,a}
package io_port_pkg;

    localparam logic [11:0] IO_BASE = 12'hFFF;
    localparam logic [15:0] IO_DISP = 16'hFFF0;
    localparam logic [15:0] IO_SW   = 16'hFFF2;
    localparam logic [15:0] IO_EDGE = 16'hFFF4;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - data-memory bus slice seen by the I/O port
// Purpose: groups the CPU data-port signals forwarded to io_port_ctrl.
//   dmemaddr/dmemwdata/dmemwrite/dmemread - CPU to port
//   io_rdata/io_sel                       - port to data-memory read mux
interface io_port_ctrl_if;

    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] io_rdata;
    logic        io_sel;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread,
        input  io_rdata, io_sel
    );

    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread,
        output io_rdata, io_sel
    );

endinterface

// File: rtl/io_port_ctrl_sw_debounce.sv
// rtl/io_port_ctrl_sw_debounce.sv - two-flop synchroniser plus level debouncer
// Purpose: accepts a raw switch level once it has differed from the stable
// value for DB_COUNT consecutive cycles.
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   raw    - raw pin, asynchronous to clock
//   stable - debounced level
//   rise   - one-cycle pulse marking a 0->1 change of stable
module sw_debounce #(
    parameter int DB_COUNT = 50000,
    parameter int DB_WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                stable_q, stable_d;
    logic [DB_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // rise is asserted in the cycle whose closing edge flips stable to 1,
    // so a flag register fed by it sets on the same edge as stable.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise     = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_WIDTH'(DB_COUNT - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise     = sync2_q;
        end else begin
            cnt_d = cnt_q + DB_WIDTH'(1);
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped switch/display port on the data bus
// Purpose: decodes the 0xFFF0-0xFFFF window, holds the display digit and
// the sticky switch edge flags, and drives the read mux.
//   clock, reset          - system clock, asynchronous active-low reset
//   bus (slave)           - CPU data-port slice and read data / select
//   io_sw0, io_sw1        - raw slide switches
//   io_display            - active-low segments {g,f,e,d,c,b,a}
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int DB_COUNT = 50000,
    parameter int DB_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    io_port_ctrl_if.slave        bus,
    input  logic                 io_sw0,
    input  logic                 io_sw1,
    output logic [6:0]           io_display
);

    logic [3:0] digit_q, digit_d;
    logic [1:0] edge_q, edge_d;
    logic [1:0] stable;
    logic [1:0] rise;
    logic       sel;
    logic       disp_wr;
    logic       edge_rd;

    sw_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db0 (
        .clock  (clock),
        .reset  (reset),
        .raw    (io_sw0),
        .stable (stable[0]),
        .rise   (rise[0])
    );

    sw_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db1 (
        .clock  (clock),
        .reset  (reset),
        .raw    (io_sw1),
        .stable (stable[1]),
        .rise   (rise[1])
    );

    assign sel     = (bus.dmemaddr[15:4] == IO_BASE);
    assign disp_wr = sel && bus.dmemwrite && (bus.dmemaddr == IO_DISP);
    assign edge_rd = sel && bus.dmemread && (bus.dmemaddr == IO_EDGE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_q <= 4'h0;
            edge_q  <= 2'b00;
        end else begin
            digit_q <= digit_d;
            edge_q  <= edge_d;
        end
    end

    // A new rising edge in the same cycle as the clearing read survives,
    // so the event is reported on the following read.
    always_comb begin
        digit_d = digit_q;
        edge_d  = edge_q;
        if (disp_wr) begin
            digit_d = bus.dmemwdata[3:0];
        end
        if (edge_rd) begin
            edge_d = 2'b00;
        end
        edge_d = edge_d | rise;
    end

    always_comb begin
        bus.io_rdata = 16'h0000;
        if (sel) begin
            case (bus.dmemaddr)
                IO_DISP: bus.io_rdata = {12'h000, digit_q};
                IO_SW:   bus.io_rdata = {14'b0, stable};
                IO_EDGE: bus.io_rdata = {14'b0, edge_q};
                default: bus.io_rdata = 16'h0000;
            endcase
        end
    end

    assign bus.io_sel = sel;
    assign io_display = hex_to_seg(digit_q);

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- Memory-mapped I/O port on the LEGLite data-memory bus, sitting between the pipelined CPU's data port and the board pins.
- Synchronises and debounces the two slide switches, and latches rising-edge event flags that are cleared when read.
- Holds a hex digit register that drives the 7-segment display.
- The data-memory device forwards accesses in the 0xFFF0–0xFFFF window here and muxes `io_rdata` into its read data whenever `io_sel` is high.

Parameters:
- DB_COUNT, 50000: consecutive cycles a synchronised switch level must differ from the stable value before it is accepted.
- DB_WIDTH, 16: width of each debounce counter; must satisfy 2^DB_WIDTH > DB_COUNT.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- dmemaddr  in  16  data memory address from the CPU
- dmemwdata  in  16  write data from the CPU
- dmemwrite  in  1  write enable
- dmemread  in  1  read enable
- io_sw0  in  1  raw slide switch 0, asynchronous to clock
- io_sw1  in  1  raw slide switch 1, asynchronous to clock
- io_rdata  out  16  read data; combinational from address and state
- io_sel  out  1  combinational; 1 when dmemaddr[15:4] == 12'hFFF
- io_display  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset is asynchronous and active-low. While reset is low, every register clears:
  - sync flops, stable switch values, debounce counters and edge flags go to 0;
  - the display digit goes to 4'h0, so io_display = 7'b1000000.
- Combinational outputs during reset follow that state: io_rdata reflects the cleared registers and io_sel tracks the address.
- Address map (word addresses; other addresses in the window read 0 and ignore writes):
  - 0xFFF0 DISP (R/W): write loads the digit from dmemwdata[3:0]; read returns {12'b0, digit}.
  - 0xFFF2 SW (R): returns {14'b0, stable_sw1, stable_sw0}; writes ignored.
  - 0xFFF4 EDGE (R, clear-on-read): returns {14'b0, edge1, edge0}; writes ignored.
- Outside the window: io_sel = 0, io_rdata = 16'h0000, and nothing is updated.
- Read path:
  - io_rdata is combinational, so it is valid in the same cycle as dmemread, matching single-cycle memory timing.
  - The EDGE clear takes effect at the rising clock edge ending a cycle with dmemread=1 and address 0xFFF4.
- Synchroniser: each raw switch passes through two flops (sync1 → sync2) before the debouncer.
- Debounce, per switch:
  - If sync2 == stable, the counter resets to 0.
  - Otherwise the counter increments.
  - When the counter equals DB_COUNT-1 while still differing, then on that edge: stable <= sync2 and counter <= 0.
  - A change is therefore accepted DB_COUNT cycles after it reaches sync2, i.e. 2 + DB_COUNT cycles after the pin changes.
  - Any return to the stable level in between restarts the count; glitches shorter than DB_COUNT are never seen.
- Edge flags:
  - edgeN sets on the cycle stableN transitions 0→1.
  - It is sticky until cleared by an EDGE read.
  - If a set and a clear occur in the same cycle, the set wins so the event is not lost.
  - 1→0 transitions do not set a flag.
- Display encoding: combinational hex-to-7-seg, active-low, digits 0–F.
  - Examples: 0 → 1000000, 5 → 0010010, A → 0001000, F → 0001110.
- Simultaneous dmemwrite and dmemread are both honoured: a DISP write and an EDGE clear can occur in the same cycle.
- Reset asserted mid-debounce discards the partial count. After reset releases, the switch is re-evaluated from stable = 0.

Decomposition:
- Package io_port_pkg contains:
  - the address constants IO_BASE, IO_DISP, IO_SW and IO_EDGE;
  - the hex-to-segment function (active-low table).
- Sub-module sw_debounce, instantiated twice with parameters DB_COUNT and DB_WIDTH:
  - inputs clock, reset, raw;
  - outputs stable and rise, where rise is a one-cycle pulse on each 0→1 transition of stable.
- The top level holds the address decode, the display register, the edge flags and the read mux.

Test Plan (bench uses DB_COUNT=4):
- Reset: assert reset low with the switches high → io_display = 1000000, SW and EDGE read 0; after release, sw0 becomes 1 in SW 6 cycles later and edge0 = 1.
- Display write: write 0x0005 to 0xFFF0 → io_display = 0010010 on the next cycle; DISP read returns 0x0005. Then write 0xFFFA → display shows A (0001000).
- Glitch rejection: pulse io_sw0 high for 3 cycles → SW stays 0 and EDGE stays 0. Hold it high for 10 cycles → SW bit0 = 1 exactly 6 cycles after the pin rises.
- Clear-on-read: with edge0 set, read 0xFFF4 → returns 0x0001; the next read returns 0x0000. Make stable0 rise in the same cycle as an EDGE read → the flag remains 1 afterwards.
- Reset mid-debounce: raise io_sw1, then pulse reset low 3 cycles later → the counter is cleared and SW bit1 = 1 only 6 cycles after reset release.
- Decode: access 0x0010 and 0xFFF8 with read and write → at 0x0010 io_sel = 0 and io_rdata = 0; at 0xFFF8 io_sel = 1 and io_rdata = 0; in neither case do the display or the flags change.
